// File: rtl/store_image.sv
// store_image: DMA write-back engine for a CNN layer result.
// Reads an N x N feature map (N = img_size clamped to 32) from the result
// buffer, packs it into BLOCK_SIZE-word blocks (tail zero-padded) and hands
// each block to the DMA controller at consecutive external addresses.
// Optional build macro STORE_IMAGE_RELU_EN applies ReLU to captured words.
module store_image #(
  parameter int MEM_ADDR_SIZE = 20,
  parameter int DATA_SIZE     = 16,
  parameter int BLOCK_SIZE    = 25,
  parameter int BUF_ADDR_SIZE = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [DATA_SIZE-1:0]            img_size,
  input  logic [MEM_ADDR_SIZE-1:0]        init_addr,
  output logic                            src_rd_en,
  output logic [BUF_ADDR_SIZE-1:0]        src_addr,
  input  logic [DATA_SIZE-1:0]            src_data,
  output logic                            dma_enable,
  input  logic                            dma_ack,
  output logic                            rw,
  output logic [MEM_ADDR_SIZE-1:0]        address,
  output logic [BLOCK_SIZE*DATA_SIZE-1:0] block_out,
  output logic                            busy,
  output logic                            done
);

  localparam int MAX_N  = 32;
  localparam int CNT_W  = 11;                      // holds 32*32 = 1024
  localparam int SLOT_W = $clog2(BLOCK_SIZE + 1);  // counts 0..BLOCK_SIZE

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_NEXT, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  total;     // N*N words in this feature map
  logic [CNT_W-1:0]  w;         // next buffer word to request
  logic [SLOT_W-1:0] j;         // FILL cycle within the current block
  logic              rd_q;      // a read was issued last cycle
  logic [5:0]        n_clamp;
  logic [CNT_W-1:0]  total_in;
  logic [SLOT_W-1:0] slot_idx;
  logic [DATA_SIZE-1:0] cap_word;

  // Clamp the side length and form the word count from the live inputs.
  assign n_clamp  = (img_size > DATA_SIZE'(MAX_N)) ? 6'(MAX_N) : img_size[5:0];
  assign total_in = CNT_W'(n_clamp) * CNT_W'(n_clamp);

  // Data requested in FILL cycle j-1 arrives in cycle j and fills slot j-1.
  assign slot_idx = j - SLOT_W'(1);

`ifdef STORE_IMAGE_RELU_EN
  // Negative two's-complement words are clamped to zero on capture.
  assign cap_word = src_data[DATA_SIZE-1] ? '0 : src_data;
`else
  assign cap_word = src_data;
`endif

  // Transfer sequencer: all outputs are registered here. The request for
  // the first slot of a block is issued on the edge that enters FILL, so a
  // block takes exactly BLOCK_SIZE+1 FILL cycles. The last block is detected
  // when the read pointer has passed the map (equivalent to blk+1 == blocks).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      src_rd_en  <= 1'b0;
      src_addr   <= '0;
      dma_enable <= 1'b0;
      rw         <= 1'b1;
      address    <= '0;
      // NOTE: block_out is a flat register bank rather than a RAM, so it
      // can take a reset without blocking RAM inference.
      block_out  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      total      <= '0;
      w          <= '0;
      j          <= '0;
      rd_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // reads the pre-edge value of each register regardless of order.
      rd_q <= src_rd_en;
      case (state)
        S_IDLE: begin
          if (start) begin
            total    <= total_in;
            address  <= init_addr;
            rw       <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
            j        <= '0;
            src_addr <= '0;
            w        <= CNT_W'(1);
            if (total_in == '0) begin
              state <= S_DONE;
            end else begin
              src_rd_en <= 1'b1;
              state     <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (j != '0)
            block_out[int'(slot_idx)*DATA_SIZE +: DATA_SIZE] <= rd_q ? cap_word : '0;
          if (j >= SLOT_W'(BLOCK_SIZE - 1)) begin
            src_rd_en <= 1'b0;
          end else begin
            src_rd_en <= (w < total);
            src_addr  <= BUF_ADDR_SIZE'(w);
            w         <= w + CNT_W'(1);
          end
          if (j == SLOT_W'(BLOCK_SIZE)) begin
            dma_enable <= 1'b1;
            state      <= S_ISSUE;
          end
          j <= j + SLOT_W'(1);
        end

        S_ISSUE: begin
          if (dma_ack) begin
            dma_enable <= 1'b0;
            state      <= S_NEXT;
          end
        end

        S_NEXT: begin
          address <= address + MEM_ADDR_SIZE'(BLOCK_SIZE);
          if (w >= total) begin
            state <= S_DONE;
          end else begin
            j         <= '0;
            src_rd_en <= 1'b1;
            src_addr  <= BUF_ADDR_SIZE'(w);
            w         <= w + CNT_W'(1);
            state     <= S_FILL;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          rw    <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_image.sv
// tb_store_image: randomized self-checking bench for store_image.
// A synchronous-RAM model serves the result buffer; a DMA responder acks
// each block after a chosen delay. Expected blocks, addresses, read counts
// and completion latency come from a reference model of the transfer rules.
module tb_store_image;

  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int BS  = 25;
  localparam int BAW = 10;
  localparam int BW  = BS * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] img_size = '0;
  logic [AW-1:0] init_addr = '0;
  logic          src_rd_en;
  logic [BAW-1:0] src_addr;
  logic [DW-1:0] src_data = '0;
  logic          dma_enable;
  logic          dma_ack = 1'b0;
  logic          rw;
  logic [AW-1:0] address;
  logic [BW-1:0] block_out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] mem [1024];
  int cur_total;

  store_image dut (
    .clk(clk), .rst(rst), .start(start), .img_size(img_size),
    .init_addr(init_addr), .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_data(src_data), .dma_enable(dma_enable), .dma_ack(dma_ack),
    .rw(rw), .address(address), .block_out(block_out), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Result buffer: one-cycle read latency, garbage when not read.
  always @(posedge clk)
    src_data <= src_rd_en ? mem[src_addr] : DW'($urandom);

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] v);
`ifdef STORE_IMAGE_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [BW-1:0] exp_block(input int b);
    logic [BW-1:0] r;
    r = '0;
    for (int k = 0; k < BS; k++) begin
      int wi;
      wi = b * BS + k;
      if (wi < cur_total) r[k*DW +: DW] = ref_word(mem[wi]);
    end
    return r;
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 1024; i++) begin
      case (mode)
        1:       mem[i] = DW'(i + 1);
        2:       mem[i] = (i % 2 == 0) ? 16'h8001 : 16'h0003;
        default: mem[i] = DW'($urandom);
      endcase
    end
  endtask

  // One transfer: start, serve DMA with ack delay d, check every block.
  // abort_blk >= 0 asserts rst during that block's ISSUE phase.
  task automatic run_job(input int n_raw, input logic [AW-1:0] a0, input int d,
                         input int mode, input bit ack_at_start, input int abort_blk);
    int n, nblk, blk, reads, total_reads, held, cycles, budget, exp_r;
    bit in_req, ack_pend, finished;
    logic [AW-1:0] exp_addr;
    fill_mem(mode);
    n         = (n_raw > 32) ? 32 : n_raw;
    cur_total = n * n;
    nblk      = (cur_total + BS - 1) / BS;
    budget    = nblk * (28 + d) + 40;
    blk = 0; reads = 0; total_reads = 0; held = 0; cycles = 0;
    in_req = 0; ack_pend = 0; finished = 0;

    @(negedge clk);
    img_size = DW'(n_raw); init_addr = a0; start = 1'b1; dma_ack = ack_at_start;
    while (!finished && cycles < budget) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (cycles == 1) begin
        check("busy_after_start", BW'(busy), BW'(1'b1));
        check("done_cleared", BW'(done), BW'(1'b0));
        check("rw_write", BW'(rw), BW'(1'b0));
      end
      if (src_rd_en) begin reads++; total_reads++; end
      exp_addr = a0 + AW'(blk * BS);
      if (ack_pend) begin
        ack_pend = 0; dma_ack = 1'b0; in_req = 0;
        check("en_drop", BW'(dma_enable), BW'(1'b0));
        exp_r = cur_total - blk * BS;
        if (exp_r > BS) exp_r = BS;
        check("blk_reads", BW'(reads), BW'(exp_r));
        blk++; reads = 0;
      end else begin
        dma_ack = 1'b0;
        if (dma_enable) begin
          if (!in_req) begin
            in_req = 1; held = 0;
            check("addr", BW'(address), BW'(exp_addr));
            check("block", block_out, exp_block(blk));
          end else begin
            check("hold_addr", BW'(address), BW'(exp_addr));
            check("hold_block", block_out, exp_block(blk));
          end
          if (abort_blk == blk && held == 3) begin
            rst = 1'b1;
            @(negedge clk);
            check("abort_en", BW'(dma_enable), BW'(1'b0));
            check("abort_busy", BW'(busy), BW'(1'b0));
            check("abort_done", BW'(done), BW'(1'b0));
            check("abort_rw", BW'(rw), BW'(1'b1));
            rst = 1'b0;
            repeat (5) @(negedge clk);
            check("abort_quiet", BW'({dma_enable, src_rd_en, busy}), BW'(3'b000));
            return;
          end
          if (held == d) begin dma_ack = 1'b1; ack_pend = 1; end
          held++;
        end
      end
      if (done) finished = 1;
    end
    check("done_seen", BW'(finished), BW'(1'b1));
    if (finished) begin
      check("latency", BW'(cycles), BW'(nblk * (28 + d) + 2));
      check("blocks", BW'(blk), BW'(nblk));
      check("total_reads", BW'(total_reads), BW'(cur_total));
      check("busy_end", BW'(busy), BW'(1'b0));
      check("rw_end", BW'(rw), BW'(1'b1));
      repeat (3) @(negedge clk);
      check("done_sticky", BW'(done), BW'(1'b1));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rd_en", BW'(src_rd_en), BW'(1'b0));
    check("rst_src_addr", BW'(src_addr), BW'(0));
    check("rst_dma_en", BW'(dma_enable), BW'(1'b0));
    check("rst_rw", BW'(rw), BW'(1'b1));
    check("rst_address", BW'(address), BW'(0));
    check("rst_block", block_out, BW'(0));
    check("rst_busy", BW'(busy), BW'(1'b0));
    check("rst_done", BW'(done), BW'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    run_job(5, 20'h00100, 1, 1, 1'b0, -1);   // basic, words 1..25
    run_job(6, 20'h00000, 0, 0, 1'b1, -1);   // padding, stray ack with start
    run_job(5, 20'h12345, 10, 0, 1'b0, -1);  // backpressure
    run_job(0, 20'h00AAA, 0, 0, 1'b0, -1);   // zero size
    run_job(10, 20'h00200, 20, 0, 1'b0, 1);  // reset during block 2 ISSUE
    run_job(5, 20'h00300, 0, 0, 1'b0, -1);   // recovery after reset
    run_job(5, 20'h00000, 1, 2, 1'b0, -1);   // alternating 0x8001 / 0x0003
    run_job(40, 20'hFFFF0, 2, 0, 1'b0, -1);  // clamp to 32, address wrap
    for (int t = 0; t < 8; t++)
      run_job(int'($urandom_range(0, 34)), AW'($urandom), int'($urandom_range(0, 3)),
              0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
